iob_uart_tx_arb: RTL and testbench

//  Shares the single uart_core transmitter among N_REQ byte-stream requesters (e.g. CPU console, debug, trace).

---
 rtl/iob_uart_pkg.sv | 13 +
 rtl/iob_rr_pick.sv | 33 +++
 rtl/iob_uart_tx_arb.sv | 151 +++++++++++++++
 tb/tb_iob_uart_tx_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter FSM encoding and default byte width.
package iob_uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N_REQ.
module iob_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    cand     = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    // Scan from the far end so the nearest candidate to ptr_i is written last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        idx_o = cand[IDX_W-1:0];
        any_o = 1'b1;
      end
    end
    onehot_o = any_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/iob_uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one uart_core transmitter among N_REQ byte streams.
module iob_uart_tx_arb
  import iob_uart_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    rst_soft_i,
  input  logic                    arb_en_i,
  input  logic [TMO_W-1:0]        tmo_cycles_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  input  logic                    tx_ready_i,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_wr_o,
  output logic                    tmo_evt_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_wr_q, tx_wr_d;
  logic               tmo_evt_q, tmo_evt_d;
  logic [TMO_W-1:0]   stall_q, stall_d;
  logic               last_q, last_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  req_bytes [N_REQ];
  logic               owner_valid;
  logic               owner_last;
  logic [IDX_W-1:0]   next_ptr;
  logic               tmo_hit;
  logic               in_reset;

  iob_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  assign in_reset    = !rst_n_i || rst_soft_i;
  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign next_ptr    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign tmo_hit     = (tmo_cycles_i != '0) && (stall_q >= tmo_cycles_i) && !owner_valid;

  // Gated by reset so a requester never believes a byte was taken in a cycle that drops it.
  assign req_ready_o = (state_q == ST_SEND && tx_ready_i && !in_reset) ? (grant_q & req_valid_i) : '0;
  assign grant_o     = grant_q;
  assign tx_data_o   = tx_data_q;
  assign tx_wr_o     = tx_wr_q;
  assign tmo_evt_o   = tmo_evt_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    tmo_evt_d = 1'b0;
    stall_d   = stall_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en_i && pick_any) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          stall_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready_i && owner_valid) begin
          tx_data_d = req_bytes[owner_q];
          tx_wr_d   = 1'b1;
          last_d    = owner_last;
          stall_d   = '0;
          state_d   = ST_WAIT;
        end else if (tmo_hit) begin
          tmo_evt_d = 1'b1;
          grant_d   = '0;
          ptr_d     = next_ptr;
          state_d   = ST_IDLE;
        end else if (tx_ready_i && stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      // The core needs a cycle to drop tx_ready after the strobe, so it is not sampled here.
      ST_WAIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (tx_ready_i) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (in_reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      tmo_evt_q <= 1'b0;
      stall_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      tmo_evt_q <= tmo_evt_d;
      stall_q   <= stall_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Directed bench for iob_uart_tx_arb: reset, single packet, fairness, packet lock, timeout, back-pressure.
module tb_iob_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst_n, rst_soft, arb_en, tx_ready;
  logic [TW-1:0]   tmo;
  logic [N-1:0]    valid, last;
  logic [N*DW-1:0] data;
  logic [N-1:0]    req_ready, grant;
  logic [DW-1:0]   tx_data;
  logic            tx_wr, tmo_evt;

  int chk  = 0;
  int pass = 0;

  always #5 clk = ~clk;

  iob_uart_tx_arb #(.N_REQ(N), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rst_soft_i   (rst_soft),
    .arb_en_i     (arb_en),
    .tmo_cycles_i (tmo),
    .req_valid_i  (valid),
    .req_data_i   (data),
    .req_last_i   (last),
    .req_ready_o  (req_ready),
    .grant_o      (grant),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data),
    .tx_wr_o      (tx_wr),
    .tmo_evt_o    (tmo_evt)
  );

  always @(posedge clk) begin
    if (rst_n && tx_wr) $display("[%0t] tx byte %02h grant %b", $time, tx_data, grant);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_soft = 1'b0; arb_en = 1'b1; tx_ready = 1'b1; tmo = '0;
    valid = '1; last = '1; data = 32'h44332211;
    repeat (5) begin
      tick();
      chk++; if (grant !== 4'b0000) $display("FAIL rst_grant got=%b exp=0000", grant); else pass++;
      chk++; if (tx_wr !== 1'b0) $display("FAIL rst_tx_wr got=%b exp=0", tx_wr); else pass++;
      chk++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", req_ready); else pass++;
    end
    chk++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", tx_data); else pass++;
    valid = '0; last = '0; data = '0; rst_n = 1'b1;
    tick();
    chk++; if (grant !== 4'b0000) $display("FAIL rst_idle_grant got=%b exp=0000", grant); else pass++;
  endtask

  task automatic test_single_packet();
    arb_en = 1'b0; valid[0] = 1'b1; data[7:0] = 8'h41; last[0] = 1'b0;
    tick();
    chk++; if (grant !== 4'b0000) $display("FAIL sp_arb_off got=%b exp=0000", grant); else pass++;
    arb_en = 1'b1;
    tick();
    chk++; if (grant !== 4'b0001) $display("FAIL sp_grant got=%b exp=0001", grant); else pass++;
    chk++; if (req_ready !== 4'b0001) $display("FAIL sp_ready got=%b exp=0001", req_ready); else pass++;
    tick();
    chk++; if (tx_wr !== 1'b1) $display("FAIL sp_wr1 got=%b exp=1", tx_wr); else pass++;
    chk++; if (tx_data !== 8'h41) $display("FAIL sp_data1 got=%h exp=41", tx_data); else pass++;
    chk++; if (req_ready !== 4'b0000) $display("FAIL sp_wait_ready got=%b exp=0000", req_ready); else pass++;
    data[7:0] = 8'h42; last[0] = 1'b1;
    tick();
    chk++; if (tx_wr !== 1'b0) $display("FAIL sp_hold_wr got=%b exp=0", tx_wr); else pass++;
    tick();
    chk++; if (req_ready !== 4'b0001) $display("FAIL sp_ready2 got=%b exp=0001", req_ready); else pass++;
    tick();
    chk++; if (tx_wr !== 1'b1) $display("FAIL sp_wr2 got=%b exp=1", tx_wr); else pass++;
    chk++; if (tx_data !== 8'h42) $display("FAIL sp_data2 got=%h exp=42", tx_data); else pass++;
    valid[0] = 1'b0; last[0] = 1'b0;
    tick();
    chk++; if (grant !== 4'b0001) $display("FAIL sp_hold_grant got=%b exp=0001", grant); else pass++;
    tick();
    chk++; if (grant !== 4'b0000) $display("FAIL sp_release got=%b exp=0000", grant); else pass++;
    // Pointer now 1: with req0 and req1 both pending, req1 must win.
    valid = 4'b0011; last = 4'b0011; data[15:8] = 8'h51;
    tick();
    chk++; if (grant !== 4'b0010) $display("FAIL sp_rr_ptr got=%b exp=0010", grant); else pass++;
    rst_soft = 1'b1;
    #1;
    chk++; if (req_ready !== 4'b0000) $display("FAIL sp_soft_ready got=%b exp=0000", req_ready); else pass++;
    tick();
    rst_soft = 1'b0; valid = '0; last = '0;
    chk++; if (grant !== 4'b0000) $display("FAIL sp_soft_grant got=%b exp=0000", grant); else pass++;
    chk++; if (tx_wr !== 1'b0) $display("FAIL sp_soft_wr got=%b exp=0", tx_wr); else pass++;
    chk++; if (tx_data !== 8'h00) $display("FAIL sp_soft_data got=%h exp=00", tx_data); else pass++;
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    logic [7:0] ed;
    valid = '1; last = '1; data = 32'h13121110;
    for (int i = 0; i < 8; i++) begin
      eg = 4'b0001 << (i % 4);
      ed = 8'h10 + 8'(i % 4);
      tick();
      chk++; if (grant !== eg) $display("FAIL fair_grant%0d got=%b exp=%b", i, grant, eg); else pass++;
      tick();
      chk++; if (tx_data !== ed) $display("FAIL fair_data%0d got=%h exp=%h", i, tx_data, ed); else pass++;
      tick();
      tick();
      chk++; if (grant !== 4'b0000) $display("FAIL fair_idle%0d got=%b exp=0000", i, grant); else pass++;
    end
    valid = '0; last = '0;
  endtask

  task automatic test_packet_lock();
    logic [7:0] ed;
    valid = 4'b0110; last = 4'b0100; data[15:8] = 8'hA1; data[23:16] = 8'hC0;
    for (int b = 0; b < 3; b++) begin
      ed = 8'hA1 + 8'(b);
      tick();
      chk++; if (grant !== 4'b0010) $display("FAIL lock_grant%0d got=%b exp=0010", b, grant); else pass++;
      chk++; if (req_ready !== 4'b0010) $display("FAIL lock_ready%0d got=%b exp=0010", b, req_ready); else pass++;
      tick();
      chk++; if (tx_data !== ed) $display("FAIL lock_data%0d got=%h exp=%h", b, tx_data, ed); else pass++;
      if (b == 0) data[15:8] = 8'hA2;
      if (b == 1) begin data[15:8] = 8'hA3; last[1] = 1'b1; end
      if (b == 2) begin valid[1] = 1'b0; last[1] = 1'b0; end
      tick();
    end
    tick();
    chk++; if (grant !== 4'b0000) $display("FAIL lock_idle got=%b exp=0000", grant); else pass++;
    tick();
    chk++; if (grant !== 4'b0100) $display("FAIL lock_next got=%b exp=0100", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'hC0) $display("FAIL lock_req2_data got=%h exp=c0", tx_data); else pass++;
    valid = '0; last = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    tmo = 16'd5; valid = 4'b1001; last = 4'b0001; data[31:24] = 8'hD3; data[7:0] = 8'hE0;
    tick();
    chk++; if (grant !== 4'b1000) $display("FAIL tmo_grant got=%b exp=1000", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'hD3) $display("FAIL tmo_data got=%h exp=d3", tx_data); else pass++;
    valid[3] = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      tick();
      chk++; if (tmo_evt !== 1'b0) $display("FAIL tmo_early%0d got=%b exp=0", s, tmo_evt); else pass++;
    end
    tick();
    chk++; if (tmo_evt !== 1'b1) $display("FAIL tmo_evt got=%b exp=1", tmo_evt); else pass++;
    chk++; if (grant !== 4'b0000) $display("FAIL tmo_release got=%b exp=0000", grant); else pass++;
    tick();
    chk++; if (tmo_evt !== 1'b0) $display("FAIL tmo_pulse got=%b exp=0", tmo_evt); else pass++;
    chk++; if (grant !== 4'b0001) $display("FAIL tmo_next got=%b exp=0001", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'hE0) $display("FAIL tmo_next_data got=%h exp=e0", tx_data); else pass++;
    valid = '0; last = '0;
    tick();
    tick();
    // Timeout disabled: owner keeps the TX through a long stall.
    tmo = '0; valid = 4'b0110; last = 4'b0100; data[15:8] = 8'hB1; data[23:16] = 8'hC5;
    tick();
    chk++; if (grant !== 4'b0010) $display("FAIL tmo0_grant got=%b exp=0010", grant); else pass++;
    tick();
    valid[1] = 1'b0;
    tick();
    tick();
    bad = 0;
    repeat (40) begin
      tick();
      if (tmo_evt !== 1'b0 || grant !== 4'b0010) bad++;
    end
    chk++; if (bad != 0) $display("FAIL tmo0_hold got=%0d bad cycles exp=0", bad); else pass++;
    valid[1] = 1'b1; data[15:8] = 8'hB9; last[1] = 1'b1;
    tick();
    chk++; if (tx_data !== 8'hB9) $display("FAIL tmo0_last_data got=%h exp=b9", tx_data); else pass++;
    valid[1] = 1'b0; last[1] = 1'b0;
    tick();
    tick();
    tick();
    chk++; if (grant !== 4'b0100) $display("FAIL tmo0_next got=%b exp=0100", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'hC5) $display("FAIL tmo0_req2_data got=%h exp=c5", tx_data); else pass++;
    valid = '0; last = '0;
    tick();
    tick();
  endtask

  task automatic test_back_pressure();
    int bad;
    tmo = 16'd5; valid[3] = 1'b1; data[31:24] = 8'h31; last[3] = 1'b0;
    tick();
    chk++; if (grant !== 4'b1000) $display("FAIL bp_grant got=%b exp=1000", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'h31) $display("FAIL bp_data got=%h exp=31", tx_data); else pass++;
    data[31:24] = 8'h32;
    tick();
    tick();
    chk++; if (req_ready !== 4'b1000) $display("FAIL bp_ready got=%b exp=1000", req_ready); else pass++;
    rst_soft = 1'b1;
    #1;
    chk++; if (req_ready !== 4'b0000) $display("FAIL bp_soft_ready got=%b exp=0000", req_ready); else pass++;
    tick();
    chk++; if (grant !== 4'b0000) $display("FAIL bp_soft_grant got=%b exp=0000", grant); else pass++;
    chk++; if (tx_wr !== 1'b0) $display("FAIL bp_soft_wr got=%b exp=0", tx_wr); else pass++;
    rst_soft = 1'b0; valid[0] = 1'b1; data[7:0] = 8'h0F; last = 4'b1001;
    tick();
    chk++; if (grant !== 4'b0001) $display("FAIL bp_soft_ptr got=%b exp=0001", grant); else pass++;
    tick();
    chk++; if (tx_data !== 8'h0F) $display("FAIL bp_req0_data got=%h exp=0f", tx_data); else pass++;
    valid[0] = 1'b0;
    tick();
    tick();
    tx_ready = 1'b0;
    tick();
    chk++; if (grant !== 4'b1000) $display("FAIL bp_grant3 got=%b exp=1000", grant); else pass++;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      valid[3] = (c < 50);
      tick();
      if (tx_wr !== 1'b0 || tmo_evt !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b1000) bad++;
    end
    chk++; if (bad != 0) $display("FAIL bp_stall got=%0d bad cycles exp=0", bad); else pass++;
    tx_ready = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (tmo_evt !== 1'b0) bad++;
    end
    chk++; if (bad != 0) $display("FAIL bp_no_early_tmo got=%0d exp=0", bad); else pass++;
    tick();
    chk++; if (tmo_evt !== 1'b1) $display("FAIL bp_tmo got=%b exp=1", tmo_evt); else pass++;
    chk++; if (grant !== 4'b0000) $display("FAIL bp_tmo_release got=%b exp=0000", grant); else pass++;
    valid = '0; last = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fairness();
    test_packet_lock();
    test_timeout();
    test_back_pressure();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
